// File: rtl/alu16.sv
// 16-bit execute-stage ALU: combinational result and per-flag write enables,
// with the {Z,V,N} condition flags held in a register updated on the clock edge.
module alu16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ALU_in1,
   input  logic [15:0] ALU_in2,
   input  logic [2:0]  op,
   output logic [15:0] ALU_out,
   output logic [2:0]  flag,
   output logic [2:0]  flag_write
);

   localparam int unsigned W  = 16;
   localparam int unsigned SW = 4;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SUB    = 3'b001;
   localparam logic [2:0] OP_RED    = 3'b010;
   localparam logic [2:0] OP_XOR    = 3'b011;
   localparam logic [2:0] OP_SLL    = 3'b100;
   localparam logic [2:0] OP_SRA    = 3'b101;
   localparam logic [2:0] OP_ROR    = 3'b110;
   localparam logic [2:0] OP_PADDSB = 3'b111;

   logic [SW-1:0]       amt;
   logic [W-1:0]        b_eff;
   logic [W-1:0]        addsub_raw;
   logic                addsub_ovf;
   logic [W-1:0]        addsub_sat;
   logic [W-1:0]        red_sum;
   logic signed [W-1:0] sra_res;
   logic [W-1:0]        ror_res;
   logic [W-1:0]        paddsb_res;
   logic [4:0]          nib_sum;
   logic [2:0]          flag_next;

   assign amt = ALU_in2[SW-1:0];

   // Shared adder; SUB is A + ~B + 1, overflow judged before saturation
   always_comb begin
      b_eff      = (op == OP_SUB) ? ~ALU_in2 : ALU_in2;
      addsub_raw = ALU_in1 + b_eff + W'(op == OP_SUB);
      addsub_ovf = (ALU_in1[W-1] == b_eff[W-1]) && (addsub_raw[W-1] != ALU_in1[W-1]);
      if (addsub_ovf)
         addsub_sat = ALU_in1[W-1] ? 16'h8000 : 16'h7FFF;
      else
         addsub_sat = addsub_raw;
   end

   always_comb begin
      red_sum = {{8{ALU_in1[15]}}, ALU_in1[15:8]} + {{8{ALU_in1[7]}}, ALU_in1[7:0]}
              + {{8{ALU_in2[15]}}, ALU_in2[15:8]} + {{8{ALU_in2[7]}}, ALU_in2[7:0]};
      sra_res = $signed(ALU_in1) >>> amt;
      // Left term shifts by 16 when amt is 0, which yields zero in a 16-bit context
      ror_res = (ALU_in1 >> amt) | (ALU_in1 << (5'd16 - {1'b0, amt}));
   end

   // Four independent saturating signed nibble adds
   always_comb begin
      paddsb_res = '0;
      nib_sum    = '0;
      for (int i = 0; i < 4; i++) begin
         nib_sum = {ALU_in1[4*i+3], ALU_in1[4*i +: 4]} + {ALU_in2[4*i+3], ALU_in2[4*i +: 4]};
         if (nib_sum[4] != nib_sum[3])
            paddsb_res[4*i +: 4] = nib_sum[4] ? 4'h8 : 4'h7;
         else
            paddsb_res[4*i +: 4] = nib_sum[3:0];
      end
   end

   always_comb begin
      ALU_out    = addsub_sat;
      flag_write = 3'b000;
      case (op)
         OP_ADD:    begin ALU_out = addsub_sat;         flag_write = 3'b111; end
         OP_SUB:    begin ALU_out = addsub_sat;         flag_write = 3'b111; end
         OP_RED:    begin ALU_out = red_sum;            flag_write = 3'b000; end
         OP_XOR:    begin ALU_out = ALU_in1 ^ ALU_in2;  flag_write = 3'b100; end
         OP_SLL:    begin ALU_out = ALU_in1 << amt;     flag_write = 3'b100; end
         OP_SRA:    begin ALU_out = sra_res;            flag_write = 3'b100; end
         OP_ROR:    begin ALU_out = ror_res;            flag_write = 3'b100; end
         OP_PADDSB: begin ALU_out = paddsb_res;         flag_write = 3'b000; end
         default:   begin ALU_out = addsub_sat;         flag_write = 3'b000; end
      endcase
   end

   assign flag_next = {(ALU_out == '0), addsub_ovf, ALU_out[W-1]};

   // Only enabled flag bits load; the rest hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flag <= 3'b000;
      else
         flag <= (flag & ~flag_write) | (flag_next & flag_write);
   end

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vectors plus random ops checked
// against an integer-arithmetic reference model of result and flags.
module tb_alu16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ALU_in1;
   logic [15:0] ALU_in2;
   logic [2:0]  op;
   logic [15:0] ALU_out;
   logic [2:0]  flag;
   logic [2:0]  flag_write;

   int          tests = 0;
   int          fails = 0;
   logic [2:0]  mflag = 3'b000;

   alu16 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ALU_in1    (ALU_in1),
      .ALU_in2    (ALU_in2),
      .op         (op),
      .ALU_out    (ALU_out),
      .flag       (flag),
      .flag_write (flag_write)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] clamp16(input int v);
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return 16'(v);
   endfunction

   function automatic int sx4(input logic [3:0] n);
      int x;
      x = int'(n);
      if (x > 7) x = x - 16;
      return x;
   endfunction

   function automatic logic [15:0] model_out(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      int          sa, sb, s;
      logic [31:0] wide;
      logic [15:0] r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (o)
         3'd0: return clamp16(sa + sb);
         3'd1: return clamp16(sa - sb);
         3'd2: begin
            s = int'($signed(a[15:8])) + int'($signed(a[7:0]))
              + int'($signed(b[15:8])) + int'($signed(b[7:0]));
            return 16'(s);
         end
         3'd3: return a ^ b;
         3'd4: begin
            wide = {16'h0000, a} << b[3:0];
            return wide[15:0];
         end
         3'd5: return 16'(sa >>> b[3:0]);
         3'd6: begin
            r = a;
            repeat (int'(b[3:0])) r = {r[0], r[15:1]};
            return r;
         end
         default: begin
            r = 16'h0000;
            for (int i = 0; i < 4; i++) begin
               s = sx4(a[4*i +: 4]) + sx4(b[4*i +: 4]);
               if (s > 7)  s = 7;
               if (s < -8) s = -8;
               r[4*i +: 4] = 4'(s);
            end
            return r;
         end
      endcase
   endfunction

   function automatic logic model_ovf(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      int s;
      s = (o == 3'd1) ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
      return (s > 32767) || (s < -32768);
   endfunction

   function automatic logic [2:0] model_fw(input logic [2:0] o);
      if (o == 3'd0 || o == 3'd1) return 3'b111;
      if (o == 3'd2 || o == 3'd7) return 3'b000;
      return 3'b100;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one op between edges, check combinational outputs, then the registered flags
   task automatic apply(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      logic [2:0]  fw, nf;
      @(negedge clk);
      op = o; ALU_in1 = a; ALU_in2 = b;
      #1;
      r  = model_out(o, a, b);
      fw = model_fw(o);
      check($sformatf("out op%0d a=%h b=%h", o, a, b), ALU_out, r);
      check($sformatf("fw op%0d", o), 16'(flag_write), 16'(fw));
      nf = {(r == 16'h0000), model_ovf(o, a, b), r[15]};
      @(posedge clk);
      #1;
      mflag = (mflag & ~fw) | (nf & fw);
      check($sformatf("flag op%0d a=%h b=%h", o, a, b), 16'(flag), 16'(mflag));
   endtask

   logic [15:0] ra, rb;
   logic [15:0] edge_vals [6];

   initial begin
      rst_n = 1'b0; op = 3'd0; ALU_in1 = 16'h0000; ALU_in2 = 16'h0000;
      edge_vals[0] = 16'h0000; edge_vals[1] = 16'h7FFF; edge_vals[2] = 16'h8000;
      edge_vals[3] = 16'hFFFF; edge_vals[4] = 16'h0001; edge_vals[5] = 16'h8FFF;
      #12;
      check("reset_flag", 16'(flag), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, including the literal expected results
      for (int k = 0; k < 8; k++) apply(3'(k), 16'h0000, 16'hFFFF);
      for (int k = 0; k < 8; k++) apply(3'(k), 16'h8FFF, 16'h8FFF);
      apply(3'd0, 16'h8FFF, 16'h8FFF);
      check("add_8fff_out", ALU_out, 16'h8000);
      check("add_8fff_flag", 16'(flag), 16'h0003);
      apply(3'd1, 16'h8000, 16'h0001);
      check("sub_8000_out", ALU_out, 16'h8000);
      check("sub_8000_flag", 16'(flag), 16'h0003);
      apply(3'd0, 16'h7FFF, 16'h0001);
      check("add_7fff_out", ALU_out, 16'h7FFF);
      check("add_7fff_flag", 16'(flag), 16'h0002);
      apply(3'd7, 16'h7777, 16'h1111);
      check("paddsb_out", ALU_out, 16'h7777);
      for (int k = 4; k < 7; k++) apply(3'(k), 16'hA5C3, 16'h0000);

      // Build flags 111, then async reset between edges
      apply(3'd0, 16'h8FFF, 16'h8FFF);
      apply(3'd3, 16'h1234, 16'h1234);
      check("flags_set", 16'(flag), 16'h0007);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset", 16'(flag), 16'h0000);
      mflag = 3'b000;
      #1;
      rst_n = 1'b1;
      apply(3'd0, 16'h7FFF, 16'h0001);

      // Random ops, operands sometimes drawn from boundary values
      for (int n = 0; n < 400; n++) begin
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 16'($urandom);
         apply(3'($urandom_range(0, 7)), ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
